matriz_transposta_seq: RTL

//   Sequential, parametrised successor of the coprocessor's combinational transpose unit.

---
 rtl/matriz_transposta_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/matriz_transposta_seq.sv
// Sequential NxN matrix transpose unit: latches a source matrix on start
// and writes one result row per cycle in one of four reorder modes.
module matriz_transposta_seq #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_transposta,
    input  logic [1:0]       modo,
    input  logic [N*N*W-1:0] matrizA,
    output logic [N*N*W-1:0] matriz_resultante,
    output logic             busy,
    output logic             done_transposta
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] LAST = RW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   w_row_inv;
    logic [1:0]      r_mode;
    logic [W-1:0]    r_src [N][N];
    logic [W-1:0]    w_row [N];
    logic [N*N*W-1:0] r_res;
    logic            w_accept;

    assign w_accept  = start_transposta && (r_state != S_RUN);
    assign w_row_inv = LAST - r_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start_transposta) w_next = S_RUN;
            S_RUN:  if (r_row == LAST) w_next = S_DONE;
            S_DONE: w_next = start_transposta ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (r_state == S_RUN);
        done_transposta = (r_state == S_DONE);
    end

    // Elements of the current output row, selected by latched mode
    always_comb begin
        for (int c = 0; c < N; c++) begin
            w_row[c] = '0;
            unique case (r_mode)
                2'b00: w_row[c] = r_src[c][r_row];
                2'b01: w_row[c] = r_src[r_row][c];
                2'b10: w_row[c] = r_src[N-1-c][w_row_inv];
                2'b11: w_row[c] = r_src[N-1-c][r_row];
                default: w_row[c] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_mode <= '0;
            r_res  <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_src[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            r_row  <= '0;
            r_mode <= modo;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_src[r][c] <= matrizA[W*(c+N*r) +: W];
                end
            end
        end else if (r_state == S_RUN) begin
            for (int r = 0; r < N; r++) begin
                if (r_row == RW'(r)) begin
                    for (int c = 0; c < N; c++) begin
                        r_res[W*(c+N*r) +: W] <= w_row[c];
                    end
                end
            end
            if (r_row != LAST) r_row <= r_row + 1'b1;
        end
    end

    assign matriz_resultante = r_res;

endmodule
